fsk_tx_sequencer: RTL and testbench

Transmit-side frame sequencer for the FSK modem. It accepts bytes over a valid/ready handshake and frames them as preamble, start, 8 data bits, even parity and stop. Each symbol is held for a fixed number of TX_CLK cycles. Every symbol is converted into a 129-bit thermometer code word that drives the DCO `CODE_0..CODE_128` inputs directly, replacing the plain all-ones/all-zeros keying register.

---
 rtl/fsk_pkg.sv | 17 +
 rtl/fsk_tx_sequencer_therm_enc.sv | 14 +
 rtl/fsk_tx_sequencer.sv | 148 ++++++++++++++
 tb/tb_fsk_tx_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsk_pkg.sv
// Shared types and constants for the FSK transmit path.
// The code word width matches the DCO's CODE_0..CODE_128 inputs.
package fsk_pkg;

  localparam int CODE_W = 129;
  localparam int LVL_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    START,
    DATA,
    PARITY,
    STOP
  } fsk_state_e;

endpackage

// File: rtl/fsk_tx_sequencer_therm_enc.sv
// Combinational level-to-thermometer encoder: bit i is set iff i < level.
// Levels above CODE_W naturally saturate to all ones.
module fsk_therm_enc
  import fsk_pkg::*;
(
  input  logic [LVL_W-1:0]  level,
  output logic [CODE_W-1:0] code
);

  for (genvar i = 0; i < CODE_W; i++) begin : g_bit
    assign code[i] = (level > LVL_W'(i));
  end

endmodule

// File: rtl/fsk_tx_sequencer.sv
// FSK transmit frame sequencer: preamble, start, 8 data bits LSB first, even parity, stop.
// Each symbol is held BIT_CYCLES cycles and keyed onto the DCO as a registered thermometer code.
module fsk_tx_sequencer
  import fsk_pkg::*;
#(
  parameter int BIT_CYCLES    = 16,
  parameter int PREAMBLE_BITS = 8,
  parameter int MARK_CODE     = 96,
  parameter int SPACE_CODE    = 32
) (
  input  logic              TX_CLK,
  input  logic              RESET,
  input  logic [7:0]        DATA_IN,
  input  logic              DATA_VALID,
  output logic              DATA_READY,
  output logic [CODE_W-1:0] FSK_KEY,
  output logic              TX_BIT,
  output logic              TX_BUSY,
  output logic              FRAME_DONE
);

  localparam int SYM_W = $clog2(BIT_CYCLES);
  localparam int PRE_W = (PREAMBLE_BITS > 1) ? $clog2(PREAMBLE_BITS) : 1;
  localparam logic [SYM_W-1:0] SYM_LAST  = SYM_W'(BIT_CYCLES - 1);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'((PREAMBLE_BITS > 0) ? PREAMBLE_BITS - 1 : 0);
  localparam logic [LVL_W-1:0] MARK_LVL  = LVL_W'(MARK_CODE);
  localparam logic [LVL_W-1:0] SPACE_LVL = LVL_W'(SPACE_CODE);

  fsk_state_e       state, state_n;
  logic [SYM_W-1:0] sym_cnt, sym_cnt_n;
  logic [PRE_W-1:0] pre_cnt, pre_cnt_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       shreg, shreg_n;
  logic             parity, parity_n;
  logic             done_n;
  logic             sym_end;
  logic             accept;
  logic             tx_bit_n;
  logic [LVL_W-1:0] level_n;
  logic [CODE_W-1:0] key_n;

  // Parked DCO (level 0) whenever the sequencer is idle.
  function automatic logic [LVL_W-1:0] sym_level(input logic active, input logic b);
    if (!active) return '0;
    return b ? MARK_LVL : SPACE_LVL;
  endfunction

  assign sym_end    = (sym_cnt == SYM_LAST);
  assign DATA_READY = !RESET && ((state == IDLE) || ((state == STOP) && sym_end));
  assign accept     = DATA_VALID && DATA_READY;
  assign TX_BUSY    = (state != IDLE);

  always_comb begin
    state_n   = state;
    sym_cnt_n = sym_end ? '0 : sym_cnt + 1'b1;
    pre_cnt_n = pre_cnt;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    parity_n  = parity;
    done_n    = 1'b0;
    unique case (state)
      IDLE: begin
        sym_cnt_n = '0;
        if (accept) begin
          state_n   = (PREAMBLE_BITS == 0) ? START : PREAMBLE;
          pre_cnt_n = '0;
          bit_cnt_n = '0;
          shreg_n   = DATA_IN;
          parity_n  = 1'b0;
        end
      end
      PREAMBLE: if (sym_end) begin
        if (pre_cnt == PRE_LAST) state_n = START;
        else                     pre_cnt_n = pre_cnt + 1'b1;
      end
      START: if (sym_end) begin
        state_n   = DATA;
        bit_cnt_n = '0;
      end
      DATA: if (sym_end) begin
        parity_n = parity ^ shreg[0];
        shreg_n  = {1'b0, shreg[7:1]};
        if (bit_cnt == 3'd7) state_n = PARITY;
        else                 bit_cnt_n = bit_cnt + 1'b1;
      end
      PARITY: if (sym_end) state_n = STOP;
      STOP: if (sym_end) begin
        done_n = 1'b1;
        if (accept) begin
          // Back-to-back byte: straight into START, no preamble, no idle gap.
          state_n   = START;
          bit_cnt_n = '0;
          shreg_n   = DATA_IN;
          parity_n  = 1'b0;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Symbol value for the upcoming cycle, derived from next-state values so outputs are registered.
  always_comb begin
    tx_bit_n = 1'b0;
    unique case (state_n)
      PREAMBLE: tx_bit_n = ~pre_cnt_n[0];
      START:    tx_bit_n = 1'b0;
      DATA:     tx_bit_n = shreg_n[0];
      PARITY:   tx_bit_n = parity_n;
      STOP:     tx_bit_n = 1'b1;
      default:  tx_bit_n = 1'b0;
    endcase
  end

  assign level_n = sym_level(state_n != IDLE, tx_bit_n);

  fsk_therm_enc u_enc (
    .level (level_n),
    .code  (key_n)
  );

  always_ff @(posedge TX_CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      sym_cnt    <= '0;
      pre_cnt    <= '0;
      bit_cnt    <= '0;
      FSK_KEY    <= '0;
      TX_BIT     <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      state      <= state_n;
      sym_cnt    <= sym_cnt_n;
      pre_cnt    <= pre_cnt_n;
      bit_cnt    <= bit_cnt_n;
      FSK_KEY    <= key_n;
      TX_BIT     <= (state_n != IDLE) && tx_bit_n;
      FRAME_DONE <= done_n;
    end
  end

  always_ff @(posedge TX_CLK) begin
    shreg  <= shreg_n;
    parity <= parity_n;
  end

endmodule

// File: tb/tb_fsk_tx_sequencer.sv
// Self-checking bench for fsk_tx_sequencer: two parameterisations, symbol-list reference model.
module tb_fsk_tx_sequencer;

  localparam int CW   = 129;
  localparam int BC_A = 4, PB_A = 4, MK_A = 96,  SP_A = 32;
  localparam int BC_B = 3, PB_B = 0, MK_B = 129, SP_B = 0;

  logic          tx_clk = 1'b0;
  logic          reset;
  logic [7:0]    din_a, din_b;
  logic          vld_a, vld_b;
  logic          rdy_a, rdy_b, txb_a, txb_b, busy_a, busy_b, done_a, done_b;
  logic [CW-1:0] key_a, key_b;

  always #5 tx_clk = ~tx_clk;

  fsk_tx_sequencer #(.BIT_CYCLES(BC_A), .PREAMBLE_BITS(PB_A), .MARK_CODE(MK_A), .SPACE_CODE(SP_A)) dut_a (
    .TX_CLK(tx_clk), .RESET(reset), .DATA_IN(din_a), .DATA_VALID(vld_a), .DATA_READY(rdy_a),
    .FSK_KEY(key_a), .TX_BIT(txb_a), .TX_BUSY(busy_a), .FRAME_DONE(done_a));

  fsk_tx_sequencer #(.BIT_CYCLES(BC_B), .PREAMBLE_BITS(PB_B), .MARK_CODE(MK_B), .SPACE_CODE(SP_B)) dut_b (
    .TX_CLK(tx_clk), .RESET(reset), .DATA_IN(din_b), .DATA_VALID(vld_b), .DATA_READY(rdy_b),
    .FSK_KEY(key_b), .TX_BIT(txb_b), .TX_BUSY(busy_b), .FRAME_DONE(done_b));

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit busy;
    bit done;
    bit txb;
    bit rdy;
    int lvl;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] tx_bytes[$];
  bit         pend_done;
  bit         sel;
  int         busy_cnt, done_cnt;

  logic          o_rdy, o_txb, o_busy, o_done;
  logic [CW-1:0] o_key;
  assign o_rdy  = sel ? rdy_b  : rdy_a;
  assign o_txb  = sel ? txb_b  : txb_a;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_done = sel ? done_b : done_a;
  assign o_key  = sel ? key_b  : key_a;

  function automatic int cur_bc();    return sel ? BC_B : BC_A; endfunction
  function automatic int cur_pre();   return sel ? PB_B : PB_A; endfunction
  function automatic int cur_mark();  return sel ? MK_B : MK_A; endfunction
  function automatic int cur_space(); return sel ? SP_B : SP_A; endfunction

  function automatic logic [CW-1:0] therm(input int lvl);
    logic [CW-1:0] v;
    v = '0;
    for (int i = 0; i < CW; i++) if (i < lvl) v[i] = 1'b1;
    return v;
  endfunction

  task automatic drive(input logic v, input logic [7:0] d);
    if (sel) begin vld_b = v; din_b = d; vld_a = 1'b0; end
    else     begin vld_a = v; din_a = d; vld_b = 1'b0; end
  endtask

  task automatic push_sym(input bit b, input bit is_stop);
    exp_t e;
    for (int c = 0; c < cur_bc(); c++) begin
      e.busy = 1'b1;
      e.txb  = b;
      e.lvl  = b ? cur_mark() : cur_space();
      e.done = pend_done;
      pend_done = 1'b0;
      e.rdy  = is_stop && (c == cur_bc() - 1);
      exp_q.push_back(e);
    end
    if (is_stop) pend_done = 1'b1;
  endtask

  // Cycle-by-cycle expectation starting the cycle after the first accept.
  task automatic build_model();
    exp_t e;
    exp_q.delete();
    pend_done = 1'b0;
    for (int p = 0; p < cur_pre(); p++) push_sym((p % 2) == 0, 1'b0);
    foreach (tx_bytes[k]) begin
      push_sym(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) push_sym(tx_bytes[k][i], 1'b0);
      push_sym(^tx_bytes[k], 1'b0);
      push_sym(1'b1, 1'b1);
    end
    e.busy = 1'b0; e.txb = 1'b0; e.lvl = 0; e.done = 1'b1; e.rdy = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic run_burst(input bit noise);
    int   n_acc, wait_cyc, len, noise_at;
    exp_t e;
    build_model();
    len      = exp_q.size();
    noise_at = noise ? int'($urandom_range(len - cur_bc() - 2, 1)) : -10;
    busy_cnt = 0;
    done_cnt = 0;
    @(posedge tx_clk); #1;
    drive(1'b1, tx_bytes[0]);
    wait_cyc = 0;
    forever begin
      @(negedge tx_clk);
      if (o_rdy) break;
      wait_cyc++;
      if (wait_cyc > 20) begin
        checks++; errors++;
        $display("FAIL accept_timeout: DATA_READY=%b after %0d cycles, required 1", o_rdy, wait_cyc);
        drive(1'b0, 8'h00);
        return;
      end
    end
    @(posedge tx_clk); #1;
    n_acc = 1;
    if (tx_bytes.size() > 1) drive(1'b1, tx_bytes[1]);
    else                     drive(1'b0, 8'h00);
    for (int i = 0; i < len; i++) begin
      @(negedge tx_clk);
      e = exp_q[i];
      if (o_busy) busy_cnt++;
      if (o_done) done_cnt++;
      checks++;
      if (o_busy !== e.busy) begin errors++; $display("FAIL busy cyc=%0d: got %b, required %b", i, o_busy, e.busy); end
      checks++;
      if (o_done !== e.done) begin errors++; $display("FAIL frame_done cyc=%0d: got %b, required %b", i, o_done, e.done); end
      checks++;
      if (o_txb !== e.txb) begin errors++; $display("FAIL tx_bit cyc=%0d: got %b, required %b", i, o_txb, e.txb); end
      checks++;
      if (o_rdy !== e.rdy) begin errors++; $display("FAIL ready cyc=%0d: got %b, required %b", i, o_rdy, e.rdy); end
      checks++;
      if (o_key !== therm(e.lvl)) begin
        errors++;
        $display("FAIL fsk_key cyc=%0d: got popcount %0d (%h), required thermometer of %0d", i, $countones(o_key), o_key, e.lvl);
      end
      @(posedge tx_clk); #1;
      if (e.rdy && n_acc < tx_bytes.size()) begin
        n_acc++;
        if (n_acc < tx_bytes.size()) drive(1'b1, tx_bytes[n_acc]);
        else                         drive(1'b0, 8'h00);
      end
      if (i == noise_at)     drive(1'b1, 8'($urandom));
      if (i == noise_at + 1) drive(1'b0, 8'h00);
    end
    drive(1'b0, 8'h00);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sel   = 1'b0;
    vld_a = 1'b0; vld_b = 1'b0; din_a = 8'h00; din_b = 8'h00;
    repeat (3) @(posedge tx_clk);
    @(negedge tx_clk);
    checks++;
    if (key_a !== '0 || key_b !== '0) begin errors++; $display("FAIL reset_key: got %h / %h, required 0", key_a, key_b); end
    checks++;
    if ({busy_a, busy_b, done_a, done_b, txb_a, txb_b} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: busy=%b%b done=%b%b txb=%b%b, required all 0", busy_a, busy_b, done_a, done_b, txb_a, txb_b);
    end
    checks++;
    if ({rdy_a, rdy_b} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b%b, required 00", rdy_a, rdy_b); end
    @(posedge tx_clk); #1;
    reset = 1'b0;
    @(negedge tx_clk);
    checks++;
    if ({rdy_a, rdy_b} !== 2'b11) begin errors++; $display("FAIL ready_after_reset: got %b%b, required 11", rdy_a, rdy_b); end
    checks++;
    if ({busy_a, busy_b, done_a, done_b} !== 4'b0) begin errors++; $display("FAIL idle_after_reset: busy=%b%b done=%b%b, required 0", busy_a, busy_b, done_a, done_b); end
  endtask

  task automatic test_single_frame();
    sel = 1'b0;
    tx_bytes = '{8'hA5};
    run_burst(1'b0);
    checks++;
    if (busy_cnt != (PB_A + 11) * BC_A) begin errors++; $display("FAIL single_busy_len: got %0d, required %0d", busy_cnt, (PB_A + 11) * BC_A); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL single_done_count: got %0d, required 1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    tx_bytes = '{8'hFF, 8'h01};
    run_burst(1'b0);
    checks++;
    if (busy_cnt != (PB_A + 22) * BC_A) begin errors++; $display("FAIL b2b_busy_len: got %0d, required %0d", busy_cnt, (PB_A + 22) * BC_A); end
    checks++;
    if (done_cnt != 2) begin errors++; $display("FAIL b2b_done_count: got %0d, required 2", done_cnt); end
  endtask

  task automatic test_handshake();
    sel = 1'b0;
    tx_bytes = '{8'($urandom)};
    run_burst(1'b1);
    @(negedge tx_clk);
    checks++;
    if (busy_a !== 1'b0 || rdy_a !== 1'b1) begin errors++; $display("FAIL handshake_idle: busy=%b ready=%b, required 0/1", busy_a, rdy_a); end
  endtask

  task automatic test_reset_mid_data();
    sel = 1'b0;
    @(posedge tx_clk); #1;
    drive(1'b1, 8'h3C);
    @(posedge tx_clk); #1;
    drive(1'b0, 8'h00);
    repeat ((PB_A + 1 + 3) * BC_A + 1) @(negedge tx_clk);
    checks++;
    if (txb_a !== 1'b1 || key_a !== therm(MK_A)) begin
      errors++; $display("FAIL mid_data_bit3: tx_bit=%b popcount=%0d, required 1/%0d", txb_a, $countones(key_a), MK_A);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (key_a !== '0 || txb_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++; $display("FAIL async_reset: popcount=%0d tx_bit=%b busy=%b, required 0", $countones(key_a), txb_a, busy_a);
    end
    checks++;
    if (rdy_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL async_reset_ctrl: ready=%b done=%b, required 0/0", rdy_a, done_a); end
    repeat (2) begin
      @(negedge tx_clk);
      checks++;
      if (done_a !== 1'b0) begin errors++; $display("FAIL no_done_in_reset: got %b, required 0", done_a); end
    end
    @(posedge tx_clk); #1;
    reset = 1'b0;
    @(negedge tx_clk);
    checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL no_done_after_abort: done=%b busy=%b, required 0/0", done_a, busy_a); end
    tx_bytes = '{8'h55};
    run_burst(1'b0);
  endtask

  task automatic test_params();
    sel = 1'b1;
    tx_bytes = '{8'($urandom)};
    run_burst(1'b0);
    checks++;
    if (busy_cnt != 11 * BC_B) begin errors++; $display("FAIL nopre_len: got %0d, required %0d", busy_cnt, 11 * BC_B); end
    tx_bytes = '{8'($urandom), 8'($urandom)};
    run_burst(1'b0);
    checks++;
    if (done_cnt != 2) begin errors++; $display("FAIL nopre_b2b_done: got %0d, required 2", done_cnt); end
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 8; it++) begin
      sel = 1'($urandom);
      n   = int'($urandom_range(3, 1));
      tx_bytes.delete();
      for (int k = 0; k < n; k++) tx_bytes.push_back(8'($urandom));
      run_burst((n == 1) && 1'($urandom));
      checks++;
      if (done_cnt != n) begin errors++; $display("FAIL random_done_count it=%0d: got %0d, required %0d", it, done_cnt, n); end
      repeat ($urandom_range(3, 0)) @(posedge tx_clk);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_handshake();
    test_reset_mid_data();
    test_params();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
